// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response channels between the
// core's memory-stage initiator and the data-memory responder.
//   Request  channel: req_valid_i, req_ready_o, req_write_i, req_addr_i,
//                     req_wdata_i, req_wmask_i (byte k enabled by bit k)
//   Response channel: rsp_valid_o, rsp_ready_i, rsp_rdata_o, rsp_err_o
// Signal suffixes are taken from the responder's point of view.
// Modports: master = initiator (core side), slave = responder (memory side).
interface dmem_responder_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [3:0]  req_wmask_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   modport master (
      output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i,
      output rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i,
      input  rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's load/store port.
// Accepts one request at a time, waits LATENCY cycles to model memory
// latency, performs the word access, and returns read data or an error.
// Parameters:
//   DEPTH_WORDS - number of 32-bit storage words (power of two, >= 4)
//   LATENCY     - cycles from request acceptance to response (1..15)
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset (storage array is not cleared)
//   bus   - dmem_responder_if.slave request/response channels
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input logic             clk_i,
   input logic             rst_i,
   dmem_responder_if.slave bus
);

   localparam int unsigned AW         = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t      state;
   logic [3:0]  cnt;

   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        cap_write;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wmask;

   logic [31:0] mem [DEPTH_WORDS];

   logic          accept;
   logic          enter_resp;
   logic          acc_write;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_wmask;
   logic          acc_err;
   logic [AW-1:0] acc_idx;
   logic          mem_we;
   logic [31:0]   rsp_data_next;

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = rsp_valid;
   assign bus.rsp_rdata_o = rsp_rdata;
   assign bus.rsp_err_o   = rsp_err;

   assign accept = req_ready && bus.req_valid_i;

   // The access normally uses the captured request. With LATENCY==1 the
   // access happens on the accept edge itself, so the live inputs are used.
   always_comb begin
      acc_write = cap_write;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_wmask = cap_wmask;
      if (state == ST_IDLE) begin
         acc_write = bus.req_write_i;
         acc_addr  = bus.req_addr_i;
         acc_wdata = bus.req_wdata_i;
         acc_wmask = bus.req_wmask_i;
      end
   end

   always_comb begin
      enter_resp = 1'b0;
      if (state == ST_WAIT && cnt == 4'd1) begin
         enter_resp = 1'b1;
      end else if (state == ST_IDLE && accept && LATENCY == 1) begin
         enter_resp = 1'b1;
      end
   end

   // Full 32-bit range check: addresses past the array are errors, never wraps.
   assign acc_err = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
   assign acc_idx = acc_addr[AW+1:2];
   assign mem_we  = enter_resp && acc_write && !acc_err;

   always_comb begin
      rsp_data_next = '0;
      if (!acc_err && !acc_write) begin
         rsp_data_next = mem[acc_idx];
      end
   end

   // Storage has no reset; a reset in WAIT forces state to IDLE asynchronously,
   // so mem_we is already low at the next edge and the store is dropped.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (acc_wmask[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_wmask <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cap_write <= bus.req_write_i;
                  cap_addr  <= bus.req_addr_i;
                  cap_wdata <= bus.req_wdata_i;
                  cap_wmask <= bus.req_wmask_i;
                  req_ready <= 1'b0;
                  if (enter_resp) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rsp_data_next;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (enter_resp) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rsp_data_next;
                  rsp_err   <= acc_err;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready_i) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
